// File: rtl/dqs_train_pkg.sv
// Shared types and defaults for the DQS read-delay training controller.
package dqs_train_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CLEAR  = 3'd2,
        S_SETTLE = 3'd3,
        S_SAMPLE = 3'd4,
        S_STEP   = 3'd5,
        S_CENTER = 3'd6,
        S_FIN    = 3'd7
    } state_e;

    localparam int DEF_MAX_TAPS      = 128;
    localparam int DEF_TAP_W         = 7;
    localparam int DEF_SETTLE_CYCLES = 8;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

endpackage

// File: rtl/dqs_train_window_tracker.sv
// Tracks the first/last clean tap of the sweep and derives the centre target.
module dqs_train_window_tracker
    import dqs_train_pkg::*;
#(
    parameter int TAP_W = DEF_TAP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic             good,
    input  logic [TAP_W-1:0] tap,
    output logic             seen_good,
    output logic [TAP_W-1:0] target
);

    logic             seen_good_q, seen_good_d;
    logic [TAP_W-1:0] first_q, first_d;
    logic [TAP_W-1:0] last_q, last_d;
    logic [TAP_W:0]   sum_s;

    // window bookkeeping: only the first clean tap latches first, every clean tap moves last
    always_comb begin
        seen_good_d = seen_good_q;
        first_d     = first_q;
        last_d      = last_q;
        if (clear) begin
            seen_good_d = 1'b0;
            first_d     = '0;
            last_d      = '0;
        end else if (sample_valid && good) begin
            last_d = tap;
            if (!seen_good_q) begin
                first_d     = tap;
                seen_good_d = 1'b1;
            end else begin
                first_d = first_q;
            end
        end else begin
            seen_good_d = seen_good_q;
        end
    end

    // window state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_good_q <= 1'b0;
            first_q     <= '0;
            last_q      <= '0;
        end else begin
            seen_good_q <= seen_good_d;
            first_q     <= first_d;
            last_q      <= last_d;
        end
    end

    assign sum_s     = {1'b0, first_q} + {1'b0, last_q};
    assign target    = sum_s[TAP_W:1];
    assign seen_good = seen_good_q;

endmodule

// File: rtl/dqs_delay_trainer.sv
// Read-DQS delay-line training FSM for one DDR3 lane: sweep, find clean window, centre.
// Optional DQS_TRAIN_DOUBLE_SAMPLE_EN evaluates every tap twice before judging it.
module dqs_delay_trainer
    import dqs_train_pkg::*;
#(
    parameter int MAX_TAPS      = DEF_MAX_TAPS,
    parameter int TAP_W         = DEF_TAP_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             FAB_CLK,
    input  logic             RESET_N,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [TAP_W-1:0] TAP_OUT,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    input  logic             EYE_MONITOR_EARLY,
    input  logic             EYE_MONITOR_LATE
);

    localparam int               SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(MAX_TAPS - 1);
    localparam logic [TAP_W-1:0] ONE_TAP     = TAP_W'(1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1);

    state_e           state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             phase_q, phase_d;
    logic             busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic             load_q, load_d, move_q, move_d, dir_q, dir_d, clr_q, clr_d;

    logic             clean_s, good_s, final_pass_s, sample_valid_s, seen_good_s;
    logic [TAP_W-1:0] target_s;

    assign clean_s        = !EYE_MONITOR_EARLY && !EYE_MONITOR_LATE;
    assign sample_valid_s = (state_q == S_SAMPLE) && final_pass_s;

`ifdef DQS_TRAIN_DOUBLE_SAMPLE_EN
    logic pass_q, pass_d, first_clean_q, first_clean_d;

    // pass toggles on every SAMPLE; first-pass verdict is held for the second
    always_comb begin
        pass_d        = pass_q;
        first_clean_d = first_clean_q;
        if (state_q == S_LOAD) begin
            pass_d        = 1'b0;
            first_clean_d = 1'b0;
        end else if (state_q == S_SAMPLE) begin
            pass_d        = !pass_q;
            first_clean_d = clean_s;
        end else begin
            pass_d = pass_q;
        end
    end

    // double-sample pass registers
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            pass_q        <= 1'b0;
            first_clean_q <= 1'b0;
        end else begin
            pass_q        <= pass_d;
            first_clean_q <= first_clean_d;
        end
    end

    assign final_pass_s = pass_q;
    assign good_s       = clean_s && first_clean_q;
`else
    assign final_pass_s = 1'b1;
    assign good_s       = clean_s;
`endif

    dqs_train_window_tracker #(.TAP_W(TAP_W)) u_window (
        .clk          (FAB_CLK),
        .rst_n        (RESET_N),
        .clear        (state_q == S_LOAD),
        .sample_valid (sample_valid_s),
        .good         (good_s),
        .tap          (tap_q),
        .seen_good    (seen_good_s),
        .target       (target_s)
    );

    // next state; pulse outputs are computed for the state being entered so they register in step with it
    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        settle_d = settle_q;
        phase_d  = phase_q;
        done_d   = 1'b0;
        fail_d   = 1'b0;
        load_d   = 1'b0;
        move_d   = 1'b0;
        dir_d    = dir_q;
        clr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_LOAD;
                    load_d  = 1'b1;
                    tap_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD, S_STEP: begin
                state_d  = S_CLEAR;
                clr_d    = 1'b1;
                settle_d = SETTLE_LOAD;
            end
            S_CLEAR: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q - SET_ONE;
                end
            end
            S_SAMPLE: begin
                if (!final_pass_s) begin
                    state_d  = S_CLEAR;
                    clr_d    = 1'b1;
                    settle_d = SETTLE_LOAD;
                end else if (seen_good_s && !good_s) begin
                    state_d = S_CENTER;
                    phase_d = 1'b0;
                end else if ((tap_q == LAST_TAP) || DELAY_LINE_OUT_OF_RANGE) begin
                    if (seen_good_s || good_s) begin
                        state_d = S_CENTER;
                        phase_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        fail_d  = 1'b1;
                    end
                end else begin
                    state_d = S_STEP;
                    move_d  = 1'b1;
                    dir_d   = DIR_INC;
                    tap_d   = tap_q + ONE_TAP;
                end
            end
            S_CENTER: begin
                // phase_q marks the mandatory gap after each decrement MOVE
                if (phase_q) begin
                    phase_d = 1'b0;
                end else if (tap_q > target_s) begin
                    move_d  = 1'b1;
                    dir_d   = DIR_DEC;
                    tap_d   = tap_q - ONE_TAP;
                    phase_d = 1'b1;
                end else begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    end

    // state and registered outputs
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            tap_q    <= '0;
            settle_q <= '0;
            phase_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            load_q   <= 1'b0;
            move_q   <= 1'b0;
            dir_q    <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            settle_q <= settle_d;
            phase_q  <= phase_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            load_q   <= load_d;
            move_q   <= move_d;
            dir_q    <= dir_d;
            clr_q    <= clr_d;
        end
    end

    assign BUSY                    = busy_q;
    assign DONE                    = done_q;
    assign FAIL                    = fail_q;
    assign TAP_OUT                 = tap_q;
    assign DELAY_LINE_LOAD         = load_q;
    assign DELAY_LINE_MOVE         = move_q;
    assign DELAY_LINE_DIRECTION    = dir_q;
    assign EYE_MONITOR_CLEAR_FLAGS = clr_q;

endmodule

// File: doc/dqs_delay_trainer.md
# dqs_delay_trainer

Read-DQS delay-line training controller for one DDR3 PHY lane. It drives the lane IOD's dynamic delay-line controls (load, move, direction) and eye-monitor clear. It steps the DQS delay one tap at a time, sampling the eye-monitor early/late flags at each tap. It then centres the delay in the clean window and reports the final tap. It sits in the fabric between the PHY training sequencer and each DQS lane IOD, in the `FAB_CLK` domain.

## Interface
Parameters:
- `MAX_TAPS`, 128: number of delay-line taps; the sweep covers taps 0..MAX_TAPS-1.
- `TAP_W`, 7: tap counter width; must satisfy 2^TAP_W >= MAX_TAPS.
- `SETTLE_CYCLES`, 8: wait cycles after a flag clear before sampling; must be >= 1.

Ports:
- `FAB_CLK` in 1: the block's only clock.
- `RESET_N` in 1: reset, **synchronous and active-low**.
- `START` in 1: level-sampled request; begins training when the block is idle.
- `BUSY` out 1: high while training is in progress.
- `DONE` out 1: one-cycle pulse on success.
- `FAIL` out 1: one-cycle pulse when no clean tap is found.
- `TAP_OUT` out TAP_W: current tap; holds the final tap after DONE.
- `DELAY_LINE_LOAD` out 1: one-cycle pulse that resets the delay line to tap 0.
- `DELAY_LINE_MOVE` out 1: one-cycle pulse that moves the delay line one tap.
- `DELAY_LINE_DIRECTION` out 1: 1 = increment, 0 = decrement; valid whenever MOVE is high.
- `DELAY_LINE_OUT_OF_RANGE` in 1: delay line is at its limit.
- `EYE_MONITOR_CLEAR_FLAGS` out 1: one-cycle pulse that clears the eye-monitor flags.
- `EYE_MONITOR_EARLY` in 1: eye-monitor early flag.
- `EYE_MONITOR_LATE` in 1: eye-monitor late flag.

## Operation
States: `IDLE`, `LOAD`, `CLEAR`, `SETTLE`, `SAMPLE`, `STEP`, `CENTER`, `FIN`.

- **IDLE**: On `START`=1, go to `LOAD`. `START` is ignored in every other state.
- **LOAD**: Pulse `DELAY_LINE_LOAD`. Set tap=0 and clear seen_good, first, and last. Go to `CLEAR`.
- **CLEAR**: Pulse `EYE_MONITOR_CLEAR_FLAGS`. Reload the settle counter with SETTLE_CYCLES-1. Go to `SETTLE`.
- **SETTLE**: Decrement the settle counter. At 0, go to `SAMPLE`.
- **SAMPLE**: Compute good = !EARLY && !LATE.
  - If good: set last=tap. If this is the first good tap, also set first=tap and seen_good=1.
  - If seen_good && !good: the window has closed; go to `CENTER`.
  - Else, if tap==MAX_TAPS-1 or OUT_OF_RANGE: go to `CENTER` if seen_good, otherwise pulse `FAIL` and go to `IDLE`.
  - Else go to `STEP`.
- **STEP**: Pulse MOVE with DIRECTION=1 and increment tap. Go to `CLEAR`.
- **CENTER**: Compute target = (first+last)>>1, with the sum held at TAP_W+1 bits.
  - While tap > target: pulse MOVE with DIRECTION=0, then leave one idle cycle, then decrement tap on the MOVE cycle.
  - When tap == target: go to `FIN`.
- **FIN**: Pulse `DONE`. Go to `IDLE`.

Rules:
- The sweep never increments tap past MAX_TAPS-1.
- MOVE pulses are never issued on back-to-back cycles.

## Timing
- Reset values of all outputs: `BUSY`=0, `DONE`=0, `FAIL`=0, `TAP_OUT`=0, `DELAY_LINE_LOAD`=0, `DELAY_LINE_MOVE`=0, `DELAY_LINE_DIRECTION`=0, `EYE_MONITOR_CLEAR_FLAGS`=0.
- All outputs are registered.
- `BUSY` rises the cycle after `START` is accepted. It falls in the same cycle that `DONE` or `FAIL` pulses.
- Per-tap cost: 1 (CLEAR) + SETTLE_CYCLES + 1 (SAMPLE) + 1 (STEP) cycles.
- Centering cost: 2 cycles per decrement.
- Reset mid-operation: on the cycle after `RESET_N`=0 is sampled, the block is in `IDLE` and all outputs are at their reset values. No MOVE pulse is completed.
- `EYE_MONITOR_EARLY`, `EYE_MONITOR_LATE` and `DELAY_LINE_OUT_OF_RANGE` are sampled only in `SAMPLE`.

## Configuration
- Macro: `DQS_TRAIN_DOUBLE_SAMPLE_EN`.
- Defined: each tap is evaluated twice (CLEAR→SETTLE→SAMPLE runs twice). The tap is good only if both passes are clean. OUT_OF_RANGE is checked on the second pass.
- Undefined: one pass per tap, as described in Operation.

## Structure
- Package `dqs_train_pkg` holds:
  - the state enum type;
  - the default constants for MAX_TAPS, TAP_W and SETTLE_CYCLES;
  - the DIR_INC/DIR_DEC encodings.
- Sub-module `dqs_train_window_tracker` holds seen_good/first/last and computes target. It is driven by sample_valid, good, and tap.

## Test plan
All scenarios use MAX_TAPS=16 and SETTLE_CYCLES=4 unless stated.
- Clean window at taps 3..9, EARLY below 3, LATE above 9 → 10 increment MOVEs, then 4 decrement MOVEs; `DONE` pulses; `TAP_OUT`=6.
- EARLY at every tap → 15 increment MOVEs; `FAIL` pulses once; `DONE` never pulses.
- Clean at taps 12..15 → sweep stops at tap 15; 2 decrement MOVEs; `TAP_OUT`=13.
- Clean at taps 2..7 with OUT_OF_RANGE asserted at tap 5 → center at tap 3 after 2 decrement MOVEs.
- `RESET_N`=0 during `SETTLE` at tap 4 → next cycle `BUSY`=0 and all outputs at 0. `START` pulsed while `BUSY`=1 causes no second `DELAY_LINE_LOAD`.
- With `DQS_TRAIN_DOUBLE_SAMPLE_EN` defined: tap 5 clean on the first pass but LATE on the second → tap 5 is treated as not good, and `EYE_MONITOR_CLEAR_FLAGS` pulses twice per tap.
